// File: rtl/rv_fp_decoder.sv
// rv_fp_decoder: RV32F/D decode stage with a 2-entry registered skid buffer
module rv_fp_decoder #(
  parameter bit ENABLE_DOUBLE = 1'b0,
  parameter bit ENABLE_FMA    = 1'b1,
  parameter int TAG_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [2:0]           frm,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_op,
  output logic [1:0]           out_fmt,
  output logic [2:0]           out_rm,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [4:0]           out_rs3,
  output logic [4:0]           out_rd,
  output logic                 out_rs1_int,
  output logic                 out_rd_int,
  output logic                 out_illegal,
  output logic [TAG_WIDTH-1:0] out_tag
);
  typedef struct packed {
    logic [4:0]           op;
    logic [1:0]           fmt;
    logic [2:0]           rm;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rs3;
    logic [4:0]           rd;
    logic                 rs1_int;
    logic                 rd_int;
    logic                 illegal;
    logic [TAG_WIDTH-1:0] tag;
  } uop_t;
  localparam logic [4:0] OP_LOAD = 5'd0, OP_STORE = 5'd1, OP_FMADD = 5'd2, OP_ADD = 5'd6,
    OP_SUB = 5'd7, OP_MUL = 5'd8, OP_DIV = 5'd9, OP_SQRT = 5'd10, OP_SGNJ = 5'd11,
    OP_MIN = 5'd14, OP_CVT_W = 5'd16, OP_MV_X = 5'd18, OP_LE = 5'd22, OP_CVT_F_W = 5'd23,
    OP_MV_F = 5'd25, OP_CVT_FF = 5'd26;
  logic [6:0] w_opc;
  logic [4:0] w_f5, w_rs2;
  logic [2:0] w_f3, w_rm_raw;
  logic [1:0] w_fmt, w_cnt_nxt;
  logic       w_use_rm, w_ill, w_rm_bad, w_push, w_pop;
  uop_t       w_dec, r_q0, r_q1;
  logic [1:0] r_cnt;
  logic       r_in_ready;
  assign w_opc    = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_rs2    = in_instr[24:20];
  assign w_fmt    = in_instr[26:25];
  assign w_f5     = in_instr[31:27];
  // dynamic rounding resolves to frm before legality is judged
  assign w_rm_raw = (w_f3 == 3'b111) ? frm : w_f3;
  assign w_rm_bad = (w_rm_raw == 3'b101) || (w_rm_raw[2:1] == 2'b11);
  always_comb begin
    w_dec     = '0;
    w_dec.fmt = w_fmt;
    w_dec.rs1 = in_instr[19:15];
    w_dec.rs2 = w_rs2;
    w_dec.rd  = in_instr[11:7];
    w_dec.tag = in_tag;
    w_use_rm  = 1'b0;
    w_ill     = 1'b0;
    case (w_opc)
      7'b0000111, 7'b0100111: begin
        w_dec.op      = w_opc[5] ? OP_STORE : OP_LOAD;
        w_dec.fmt     = {1'b0, w_f3[0]};
        w_dec.rs1_int = 1'b1;
        w_ill         = w_f3[2:1] != 2'b01;
      end
      7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
        w_dec.op  = OP_FMADD + {3'b0, w_opc[3:2]};
        w_dec.rs3 = w_f5;
        w_use_rm  = 1'b1;
        w_ill     = !ENABLE_FMA;
      end
      7'b1010011: begin
        case (w_f5)
          5'b00000: begin w_dec.op = OP_ADD; w_use_rm = 1'b1; end
          5'b00001: begin w_dec.op = OP_SUB; w_use_rm = 1'b1; end
          5'b00010: begin w_dec.op = OP_MUL; w_use_rm = 1'b1; end
          5'b00011: begin w_dec.op = OP_DIV; w_use_rm = 1'b1; end
          5'b01011: begin w_dec.op = OP_SQRT; w_use_rm = 1'b1; w_ill = w_rs2 != 5'd0; end
          5'b00100: begin w_dec.op = OP_SGNJ + {3'b0, w_f3[1:0]}; w_ill = w_f3 > 3'd2; end
          5'b00101: begin w_dec.op = OP_MIN + {4'b0, w_f3[0]}; w_ill = w_f3[2:1] != 2'b00; end
          5'b11000: begin
            w_dec.op     = OP_CVT_W + {4'b0, w_rs2[0]};
            w_dec.rd_int = 1'b1;
            w_use_rm     = 1'b1;
            w_ill        = w_rs2[4:1] != 4'd0;
          end
          5'b11010: begin
            w_dec.op      = OP_CVT_F_W + {4'b0, w_rs2[0]};
            w_dec.rs1_int = 1'b1;
            w_use_rm      = 1'b1;
            w_ill         = w_rs2[4:1] != 4'd0;
          end
          5'b11100: begin
            w_dec.op     = OP_MV_X + {4'b0, w_f3[0]};
            w_dec.rd_int = 1'b1;
            w_ill        = (w_f3[2:1] != 2'b00) || (w_rs2 != 5'd0) || (!w_f3[0] && w_fmt == 2'b01);
          end
          5'b10100: begin w_dec.op = OP_LE - {3'b0, w_f3[1:0]}; w_dec.rd_int = 1'b1; w_ill = w_f3 > 3'd2; end
          5'b11110: begin
            w_dec.op      = OP_MV_F;
            w_dec.rs1_int = 1'b1;
            w_ill         = (w_f3 != 3'd0) || (w_rs2 != 5'd0) || (w_fmt == 2'b01);
          end
          5'b01000: begin
            w_dec.op = OP_CVT_FF;
            w_use_rm = 1'b1;
            w_ill    = !ENABLE_DOUBLE || !((w_fmt == 2'b00 && w_rs2 == 5'd1) || (w_fmt == 2'b01 && w_rs2 == 5'd0));
          end
          default: w_ill = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
    w_ill         = w_ill || w_dec.fmt[1] || (w_dec.fmt == 2'b01 && !ENABLE_DOUBLE) || (w_use_rm && w_rm_bad);
    w_dec.rm      = (w_use_rm && !w_rm_bad) ? w_rm_raw : 3'b000;
    w_dec.illegal = w_ill;
  end
  assign w_push    = in_valid && r_in_ready && !flush;
  assign w_pop     = out_valid && out_ready;
  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
  // r_q0 is the head and drives the outputs directly; r_q1 is the skid slot
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_q0       <= '0;
      r_q1       <= '0;
      r_cnt      <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_pop) r_q0 <= (w_push && r_cnt == 2'd1) ? w_dec : r_q1;
      else if (w_push && r_cnt == 2'd0) r_q0 <= w_dec;
      if (w_push && r_cnt == 2'd1 && !w_pop) r_q1 <= w_dec;
      r_cnt      <= w_cnt_nxt;
      r_in_ready <= w_cnt_nxt < 2'd2;
    end
  end
  assign in_ready    = r_in_ready;
  assign out_valid   = r_cnt != 2'd0;
  assign out_op      = r_q0.op;
  assign out_fmt     = r_q0.fmt;
  assign out_rm      = r_q0.rm;
  assign out_rs1     = r_q0.rs1;
  assign out_rs2     = r_q0.rs2;
  assign out_rs3     = r_q0.rs3;
  assign out_rd      = r_q0.rd;
  assign out_rs1_int = r_q0.rs1_int;
  assign out_rd_int  = r_q0.rd_int;
  assign out_illegal = r_q0.illegal;
  assign out_tag     = r_q0.tag;
endmodule

// File: tb/tb_rv_fp_decoder.sv
// tb_rv_fp_decoder: scoreboard bench driving a single-precision and a double-enabled decoder in lockstep
module tb_rv_fp_decoder;
  typedef struct packed {
    logic [4:0]  op;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
    logic [4:0]  rd;
    logic        rs1_int;
    logic        rd_int;
    logic        illegal;
    logic [31:0] tag;
  } uop_t;
  localparam int LOAD = 0, STORE = 1, FMADD = 2, FNMADD = 5, ADD = 6, DIV = 9, SQRT = 10,
    SGNJX = 13, MAX = 15, CVT_W = 16, MV_X = 18, CLASS = 19, EQ = 20, LT = 21, LE = 22,
    CVT_F_WU = 24, MV_F = 25, CVT_FF = 26;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [2:0]  frm;
  logic [31:0] in_instr, in_tag;
  logic        rdy[2], vld[2], ri[2], di[2], il[2];
  logic [4:0]  op[2], rs1[2], rs2[2], rs3[2], rd[2];
  logic [1:0]  fmt[2];
  logic [2:0]  rm[2];
  logic [31:0] tg[2];
  uop_t        act[2], snap[2];
  bit          stall[2];
  uop_t        q0[$], q1[$];
  int          checks = 0, fails = 0;
  logic [31:0] tagc = 32'h100;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_act
    assign act[g] = {op[g], fmt[g], rm[g], rs1[g], rs2[g], rs3[g], rd[g], ri[g], di[g], il[g], tg[g]};
  end
  rv_fp_decoder #(.ENABLE_DOUBLE(1'b0), .ENABLE_FMA(1'b1), .TAG_WIDTH(32)) u_s (
    .clk(clk), .rst(rst), .flush(flush), .frm(frm), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld[0]), .out_ready(out_ready),
    .out_op(op[0]), .out_fmt(fmt[0]), .out_rm(rm[0]), .out_rs1(rs1[0]), .out_rs2(rs2[0]),
    .out_rs3(rs3[0]), .out_rd(rd[0]), .out_rs1_int(ri[0]), .out_rd_int(di[0]),
    .out_illegal(il[0]), .out_tag(tg[0]));
  rv_fp_decoder #(.ENABLE_DOUBLE(1'b1), .ENABLE_FMA(1'b1), .TAG_WIDTH(32)) u_d (
    .clk(clk), .rst(rst), .flush(flush), .frm(frm), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld[1]), .out_ready(out_ready),
    .out_op(op[1]), .out_fmt(fmt[1]), .out_rm(rm[1]), .out_rs1(rs1[1]), .out_rs2(rs2[1]),
    .out_rs3(rs3[1]), .out_rd(rd[1]), .out_rs1_int(ri[1]), .out_rd_int(di[1]),
    .out_illegal(il[1]), .out_tag(tg[1]));
  function automatic uop_t mk(input int o, input int f, input int r, input int a, input int b,
                              input int c, input int d, input int i1, input int i2);
    mk = {5'(o), 2'(f), 3'(r), 5'(a), 5'(b), 5'(c), 5'(d), 1'(i1), 1'(i2), 1'b0, 32'h0};
  endfunction
  function automatic uop_t ill();
    ill = '0;
    ill.illegal = 1'b1;
  endfunction
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", name, a, e);
    end
  endtask
  task automatic cmp(input int d, input uop_t a, input uop_t e);
    checks++;
    if (e.illegal ? (a.illegal !== 1'b1 || a.tag !== e.tag) : (a !== e)) begin
      fails++;
      $display("FAIL uop dut%0d tag=%0h got=%h want=%h", d, e.tag, a, e);
    end
  endtask
  // called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [31:0] ins, input int f, input uop_t e0, input uop_t e1);
    int n = 0;
    in_valid = 1'b1;
    in_instr = ins;
    frm      = 3'(f);
    in_tag   = tagc;
    while (!rdy[0] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy[0]) begin
      checks++;
      fails++;
      $display("FAIL send_timeout tag=%0h got=in_ready_low want=accept", tagc);
    end else begin
      e0.tag = tagc;
      e1.tag = tagc;
      q0.push_back(e0);
      q1.push_back(e1);
    end
    tagc++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic sendb(input logic [31:0] ins, input int f, input uop_t e);
    send(ins, f, e, e);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (stall[d]) begin
          checks++;
          if (!(vld[d] && act[d] === snap[d])) begin
            fails++;
            $display("FAIL hold dut%0d got=%h want=%h", d, act[d], snap[d]);
          end
        end
        if (vld[d] && out_ready && !flush) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            checks++;
            fails++;
            $display("FAIL extra dut%0d got=tag%0h want=none", d, tg[d]);
          end else if (d == 0) cmp(0, act[0], q0.pop_front());
          else cmp(1, act[1], q1.pop_front());
        end
        stall[d] = vld[d] && !out_ready && !flush;
        snap[d]  = act[d];
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    frm = 3'd0; in_instr = 32'h0; in_tag = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid_s", 32'(vld[0]), 32'd0);
    chk("rst_valid_d", 32'(vld[1]), 32'd0);
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    chk("rst_tag", tg[0], 32'd0);
    chk("rst_op", 32'(op[1]), 32'd0);
    @(posedge clk);
    #1;
    sendb(32'h00208053, 0, mk(ADD, 0, 0, 1, 2, 0, 0, 0, 0));
    chk("latency", 32'(vld[0]), 32'd1);
    sendb(32'h0020F053, 1, mk(ADD, 0, 1, 1, 2, 0, 0, 0, 0));
    sendb(32'h0020F053, 5, ill());
    sendb(32'h0020D053, 0, ill());
    sendb(32'h58208053, 0, ill());
    sendb(32'h58008053, 0, mk(SQRT, 0, 0, 1, 0, 0, 0, 0, 0));
    send(32'h1A208053, 0, ill(), mk(DIV, 1, 0, 1, 2, 0, 0, 0, 0));
    sendb(32'h00012087, 0, mk(LOAD, 0, 0, 2, 0, 0, 1, 1, 0));
    send(32'h00013087, 0, ill(), mk(LOAD, 1, 0, 2, 0, 0, 1, 1, 0));
    sendb(32'h00312027, 0, mk(STORE, 0, 0, 2, 3, 0, 0, 1, 0));
    sendb(32'h18208243, 0, mk(FMADD, 0, 0, 1, 2, 3, 4, 0, 0));
    sendb(32'h1820924F, 0, mk(FNMADD, 0, 1, 1, 2, 3, 4, 0, 0));
    sendb(32'hE00082D3, 0, mk(MV_X, 0, 0, 1, 0, 0, 5, 0, 1));
    sendb(32'hE00092D3, 0, mk(CLASS, 0, 0, 1, 0, 0, 5, 0, 1));
    sendb(32'hE20082D3, 0, ill());
    sendb(32'hA020A2D3, 0, mk(EQ, 0, 0, 1, 2, 0, 5, 0, 1));
    sendb(32'hA02092D3, 0, mk(LT, 0, 0, 1, 2, 0, 5, 0, 1));
    sendb(32'hA02082D3, 0, mk(LE, 0, 0, 1, 2, 0, 5, 0, 1));
    sendb(32'hC00092D3, 0, mk(CVT_W, 0, 1, 1, 0, 0, 5, 0, 1));
    sendb(32'hD010F2D3, 4, mk(CVT_F_WU, 0, 4, 1, 1, 0, 5, 1, 0));
    sendb(32'hF00082D3, 0, mk(MV_F, 0, 0, 1, 0, 0, 5, 1, 0));
    sendb(32'h2020A2D3, 0, mk(SGNJX, 0, 0, 1, 2, 0, 5, 0, 0));
    sendb(32'h282092D3, 0, mk(MAX, 0, 0, 1, 2, 0, 5, 0, 0));
    send(32'h401082D3, 0, ill(), mk(CVT_FF, 0, 0, 1, 1, 0, 5, 0, 0));
    sendb(32'h04208053, 0, ill());
    sendb(32'h00000013, 0, ill());
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    fork
      begin
        sendb(32'h00208053, 0, mk(ADD, 0, 0, 1, 2, 0, 0, 0, 0));
        sendb(32'h58008053, 0, mk(SQRT, 0, 0, 1, 0, 0, 0, 0, 0));
        sendb(32'hA020A2D3, 0, mk(EQ, 0, 0, 1, 2, 0, 5, 0, 1));
        sendb(32'h18208243, 0, mk(FMADD, 0, 0, 1, 2, 3, 4, 0, 0));
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        chk("stall_ready", 32'(rdy[0]), 32'd0);
        chk("stall_valid", 32'(vld[1]), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    out_ready = 1'b0;
    sendb(32'h00208053, 0, mk(ADD, 0, 0, 1, 2, 0, 0, 0, 0));
    sendb(32'h58008053, 0, mk(SQRT, 0, 0, 1, 0, 0, 0, 0, 0));
    in_valid = 1'b1;
    in_instr = 32'hE00092D3;
    flush    = 1'b1;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 32'(vld[0]), 32'd0);
    chk("flush_valid_d", 32'(vld[1]), 32'd0);
    chk("flush_ready", 32'(rdy[0]), 32'd1);
    chk("flush_tag", tg[0], 32'd0);
    sendb(32'h00312027, 0, mk(STORE, 0, 0, 2, 3, 0, 0, 1, 0));
    in_valid = 1'b1;
    in_instr = 32'h00208053;
    flush    = 1'b1;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_drop", 32'(vld[0]), 32'd0);
    sendb(32'h282092D3, 0, mk(MAX, 0, 0, 1, 2, 0, 5, 0, 0));
    for (int n = 0; n < 20 && (q0.size() != 0 || q1.size() != 0); n++) @(posedge clk);
    #1;
    chk("drain_s", 32'(q0.size()), 32'd0);
    chk("drain_d", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
